// File: rtl/delay_tap_calibrator.sv
// Tap-sweep calibrator for a cascade delay line: majority-votes the sampled signal per tap and locks on the first vote flip.
// Optional DLY_CAL_BACKOFF_EN: step back min(BACKOFF, edge_tap) taps after lock.
module delay_tap_calibrator #(
  parameter int N_TAPS  = 6,
  parameter int SETTLE  = 4,
  parameter int SAMPLES = 8,
  parameter int BACKOFF = 1,
  localparam int W = $clog2(N_TAPS + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         sample_in,
  output logic         dly_ce,
  output logic         dly_inc,
  output logic         dly_rst,
  output logic         busy,
  output logic         done,
  output logic         locked,
  output logic         err,
  output logic [W-1:0] edge_tap,
  output logic [W-1:0] tap_pos
);

  // One shared counter serves settle, sample and back-off phases.
  localparam int CMAX = (SETTLE > SAMPLES) ? ((SETTLE > BACKOFF) ? SETTLE : BACKOFF)
                                           : ((SAMPLES > BACKOFF) ? SAMPLES : BACKOFF);
  localparam int CW = $clog2(CMAX + 1);
  localparam int OW = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);
  localparam logic [W-1:0]  TAP_MAX     = W'(N_TAPS);

  typedef enum logic [2:0] {
    S_IDLE, S_LRST, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_BACK, S_FIN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   ones;
  logic            vote;
  logic            ref_vote;

  // Strict majority: an exact tie votes 0.
  function automatic logic majority(input logic [OW-1:0] n);
    return ({1'b0, n} << 1) > (OW+1)'(SAMPLES);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      dly_rst  <= 1'b1;
      dly_ce   <= 1'b0;
      dly_inc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      edge_tap <= '0;
      tap_pos  <= '0;
      cnt      <= '0;
      ones     <= '0;
      vote     <= 1'b0;
      ref_vote <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dly_rst <= 1'b0;
          if (start) begin
            state    <= S_LRST;
            dly_rst  <= 1'b1;
            busy     <= 1'b1;
            locked   <= 1'b0;
            err      <= 1'b0;
            edge_tap <= '0;
          end
        end
        S_LRST: begin
          dly_rst <= 1'b0;
          tap_pos <= '0;
          cnt     <= '0;
          state   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            ones  <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          ones <= ones + OW'(sample_in);
          if (cnt == SAMPLE_LAST) begin
            vote  <= majority(ones + OW'(sample_in));
            state <= S_EVAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EVAL: begin
          if (tap_pos == '0) ref_vote <= vote;
          if (tap_pos != '0 && vote != ref_vote) begin
            edge_tap <= tap_pos;
            locked   <= 1'b1;
`ifdef DLY_CAL_BACKOFF_EN
            if (BACKOFF == 0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              cnt     <= (BACKOFF < int'(tap_pos)) ? CW'(BACKOFF) : CW'(tap_pos);
              dly_ce  <= 1'b1;
              dly_inc <= 1'b0;
              state   <= S_BACK;
            end
`else
            done  <= 1'b1;
            state <= S_FIN;
`endif
          end else if (tap_pos < TAP_MAX) begin
            dly_ce  <= 1'b1;
            dly_inc <= 1'b1;
            state   <= S_STEP;
          end else begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_STEP: begin
          dly_ce  <= 1'b0;
          dly_inc <= 1'b0;
          tap_pos <= tap_pos + 1'b1;
          cnt     <= '0;
          state   <= S_SETTLE;
        end
`ifdef DLY_CAL_BACKOFF_EN
        S_BACK: begin
          // dly_ce stays high here: one decrement per cycle, tracked in tap_pos.
          tap_pos <= tap_pos - 1'b1;
          if (cnt == CW'(1)) begin
            dly_ce <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_tap_calibrator.sv
// Bench for delay_tap_calibrator: delay-line model drives per-tap sample patterns; scoreboard checks each calibration result.
module tb_delay_tap_calibrator;
  localparam int N_TAPS  = 6;
  localparam int SETTLE  = 4;
  localparam int SAMPLES = 8;
  localparam int BACKOFF = 1;
  localparam int W       = $clog2(N_TAPS + 1);
`ifdef DLY_CAL_BACKOFF_EN
  localparam int BK_EN = 1;
`else
  localparam int BK_EN = 0;
`endif

  logic         CLK, RST, start, sample_in;
  logic         dly_ce, dly_inc, dly_rst, busy, done, locked, err;
  logic [W-1:0] edge_tap, tap_pos;

  delay_tap_calibrator #(.N_TAPS(N_TAPS), .SETTLE(SETTLE), .SAMPLES(SAMPLES), .BACKOFF(BACKOFF)) dut (
    .CLK(CLK), .RST(RST), .start(start), .sample_in(sample_in),
    .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_rst(dly_rst), .busy(busy), .done(done),
    .locked(locked), .err(err), .edge_tap(edge_tap), .tap_pos(tap_pos)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int locked; int err; int edge_tap; int tap; int inc; int dec; int busy_cycles;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] pat [0:N_TAPS];
  int         line_tap = 0;
  int         since_chg = 0;
  int         inc_cnt = 0;
  int         dec_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: vote each tap from its pattern, find the first flip against tap 0.
  function automatic exp_t predict();
    exp_t e;
    int   v [0:N_TAPS];
    int   et = 0;
    int   bk = 0;
    for (int t = 0; t <= N_TAPS; t++) v[t] = ($countones(pat[t]) * 2 > SAMPLES) ? 1 : 0;
    for (int t = 1; t <= N_TAPS; t++) if (et == 0 && v[t] != v[0]) et = t;
    if (et != 0) begin
      bk = (BK_EN != 0) ? ((BACKOFF < et) ? BACKOFF : et) : 0;
      e.locked = 1; e.err = 0; e.edge_tap = et; e.tap = et - bk;
      e.inc = et; e.dec = bk;
      e.busy_cycles = 1 + (SETTLE + SAMPLES + 1) * (et + 1) + et + bk + 1;
    end else begin
      e.locked = 0; e.err = 1; e.edge_tap = 0; e.tap = N_TAPS;
      e.inc = N_TAPS; e.dec = 0;
      e.busy_cycles = 1 + (SETTLE + SAMPLES + 1) * (N_TAPS + 1) + N_TAPS + 1;
    end
    return e;
  endfunction

  function automatic logic [7:0] rand_vote(input int v);
    logic [7:0] w;
    do w = 8'($urandom); while ((($countones(w) * 2 > SAMPLES) ? 1 : 0) != v);
    return w;
  endfunction

  // Delay-line model: moves on dly_ce/dly_rst, then presents the current tap's pattern after SETTLE cycles.
  initial begin
    logic ce, inc, r;
    int   k;
    sample_in = 1'b0;
    forever begin
      @(negedge CLK);
      ce = dly_ce; inc = dly_inc; r = dly_rst;
      if (!busy) begin inc_cnt = 0; dec_cnt = 0; end
      @(posedge CLK);
      if (r) begin
        line_tap = 0; since_chg = 0;
      end else if (ce) begin
        if (inc) begin inc_cnt++; if (line_tap < N_TAPS) line_tap++; end
        else begin dec_cnt++; if (line_tap > 0) line_tap--; end
        since_chg = 0;
      end else begin
        since_chg++;
      end
      #1;
      k = since_chg;
      if (k >= SETTLE && k < SETTLE + SAMPLES) sample_in = pat[line_tap][k - SETTLE];
      else sample_in = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops an expectation on every done pulse.
  initial begin
    int   busy_cnt = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (busy) busy_cnt++; else busy_cnt = 0;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("locked", int'(locked), e.locked);
          check("err", int'(err), e.err);
          if (e.locked != 0) check("edge_tap", int'(edge_tap), e.edge_tap);
          check("tap_pos", int'(tap_pos), e.tap);
          check("line_tap", line_tap, e.tap);
          check("inc_pulses", inc_cnt, e.inc);
          check("dec_pulses", dec_cnt, e.dec);
          check("busy_cycles", busy_cnt, e.busy_cycles);
        end
      end
    end
  end

  task automatic issue_start();
    sb.push_back(predict());
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic wait_done(input bit extra_starts, input bit start_at_done);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLK);
      start = extra_starts && (i % 23 == 7);
      if (done) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end else begin
      if (start_at_done) start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("done_pulse_width", int'(done), 0);
      check("idle_after_done", int'(busy), 0);
      if (start_at_done) begin
        repeat (2) @(negedge CLK);
        check("start_at_done_ignored", int'(busy), 0);
      end
    end
  endtask

  task automatic run_cal(input bit extra_starts, input bit start_at_done);
    issue_start();
    wait_done(extra_starts, start_at_done);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; start = 1'b0;
    for (int t = 0; t <= N_TAPS; t++) pat[t] = 8'h00;
    repeat (3) @(negedge CLK);
    check("reset_dly_rst", int'(dly_rst), 1);
    check("reset_outputs", int'({busy, done, locked, err, dly_ce, dly_inc, edge_tap, tap_pos}), 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_dly_rst", int'(dly_rst), 0);

    // Clean edge at tap 3
    for (int t = 0; t <= N_TAPS; t++) pat[t] = (t < 3) ? 8'h00 : 8'hFF;
    run_cal(0, 0);
    // Constant 1: no edge
    for (int t = 0; t <= N_TAPS; t++) pat[t] = 8'hFF;
    run_cal(0, 0);
    // Noisy samples, edge at tap 1
    pat[0] = 8'h09;
    for (int t = 1; t <= N_TAPS; t++) pat[t] = 8'hB7;
    run_cal(0, 0);
    // Ties everywhere vote 0
    pat[0] = 8'h0F; pat[1] = 8'hF0; pat[2] = 8'hAA; pat[3] = 8'h55;
    pat[4] = 8'h3C; pat[5] = 8'hC3; pat[6] = 8'h99;
    run_cal(0, 0);

    // RST while sampling at tap 4, then a full rerun
    for (int t = 0; t <= N_TAPS; t++) pat[t] = (t < 6) ? 8'h00 : 8'hFF;
    issue_start();
    begin
      bit reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
        @(negedge CLK);
        if (line_tap == 4) reached = 1;
      end
      check("reach_tap4", int'(reached), 1);
    end
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_dly_rst", int'(dly_rst), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_tap_pos", int'(tap_pos), 0);
    sb.delete();
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    run_cal(0, 0);

    // Starts while busy and on the done cycle
    for (int t = 0; t <= N_TAPS; t++) pat[t] = (t < 4) ? 8'hF0 : 8'h7F;
    run_cal(1, 1);

    // Randomised sweeps
    for (int n = 0; n < 12; n++) begin
      int e  = $urandom_range(1, N_TAPS + 1);
      int rv = $urandom_range(0, 1);
      for (int t = 0; t <= N_TAPS; t++) begin
        if (t < e) pat[t] = rand_vote(rv);
        else if (t == e) pat[t] = rand_vote(1 - rv);
        else pat[t] = 8'($urandom);
      end
      run_cal(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
